// File: rtl/input_pulse_pkg.sv
// Shared types and DAC sample codes for the pulse DDS / pulse meter pair.
// Sample classification helper used by the receive-side meter.
package input_pulse_pkg;

  typedef enum logic [1:0] {
    ZERO = 2'd0,
    POS  = 2'd1,
    NEG  = 2'd2
  } sample_class_t;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    MEASURE = 2'd1,
    DIVIDE  = 2'd2
  } meter_state_t;

  localparam logic [9:0] DAC_POS  = 10'h1FF;
  localparam logic [9:0] DAC_NEG  = 10'h200;
  localparam logic [9:0] DAC_ZERO = 10'h000;

  function automatic sample_class_t classify(
    input logic [9:0] s,
    input logic [9:0] thr
  );
    logic signed [10:0] v;
    logic signed [10:0] t;
    v = {s[9], s};
    t = {1'b0, thr};
    if (v > t)
      return POS;
    else if (v < -t)
      return NEG;
    else
      return ZERO;
  endfunction

endpackage

// File: rtl/pulse_meter_div32.sv
// Restoring 32/32 divider, one quotient bit per clock.
// Result and done strobe appear 32 cycles after the start edge.
module pulse_meter_div32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        start,
  input  logic [31:0] dividend,
  input  logic [31:0] divisor,
  output logic        busy,
  output logic        done,
  output logic [31:0] quotient
);

  logic [31:0] rem;
  logic [31:0] dvs;
  logic [4:0]  cnt;
  logic [32:0] shifted;
  logic [32:0] diff;

  assign shifted  = {rem, quotient[31]};
  assign diff     = shifted - {1'b0, dvs};

  always_ff @(posedge clk) begin
    if (rst) begin
      busy     <= 1'b0;
      done     <= 1'b0;
      cnt      <= '0;
      rem      <= '0;
      dvs      <= '0;
      quotient <= '0;
    end else begin
      done <= 1'b0;
      if (start) begin
        quotient <= dividend;
        rem      <= '0;
        dvs      <= divisor;
        cnt      <= '0;
        busy     <= 1'b1;
      end else if (busy) begin
        // borrow out of bit 32 means the trial subtract went negative
        rem      <= diff[32] ? shifted[31:0] : diff[31:0];
        quotient <= {quotient[30:0], ~diff[32]};
        cnt      <= cnt + 5'd1;
        if (cnt == 5'd31) begin
          busy <= 1'b0;
          done <= 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/input_pulse_meter.sv
// Pulse repetition frequency and positive-lobe width meter.
// Build option: INPUT_PULSE_METER_GLITCH_FILTER_EN (2-sample class filter).
import input_pulse_pkg::*;

module input_pulse_meter #(
  parameter logic [31:0] F_NUM      = 32'd1_000_000,
  parameter logic [9:0]  THRESH     = 10'd128,
  parameter logic [31:0] MAX_PERIOD = 32'd4_000_000
) (
  input  logic        sys_clk,
  input  logic        sys_rst,
  input  logic [9:0]  adc_data,
  input  logic        adc_data_valid,
  output logic [15:0] f_measured,
  output logic        f_measured_valid,
  output logic [15:0] pos_width,
  output logic        overrun,
  output logic        no_signal
);

  meter_state_t  state;
  sample_class_t raw_cls;
  sample_class_t cur_cls;
  sample_class_t prev_cls;

  logic [31:0] period_cnt;
  logic [15:0] pos_cnt;
  logic        pulse_start;
  logic        lobe_end;
  logic        timeout;
  logic        div_start;
  logic        div_busy;
  logic        div_done;
  logic [31:0] quotient;
  logic [15:0] q_sat;

  assign raw_cls = classify(adc_data, THRESH);

`ifdef INPUT_PULSE_METER_GLITCH_FILTER_EN
  sample_class_t prev_raw;

  always_ff @(posedge sys_clk) begin
    if (sys_rst)
      prev_raw <= ZERO;
    else if (adc_data_valid)
      prev_raw <= raw_cls;
  end

  // a new class wins only once two valid samples agree on it
  assign cur_cls = (raw_cls == prev_raw) ? raw_cls : prev_cls;
`else
  assign cur_cls = raw_cls;
`endif

  assign pulse_start = adc_data_valid &&
                       cur_cls == POS &&
                       prev_cls != POS;
  assign lobe_end    = adc_data_valid &&
                       cur_cls != POS &&
                       prev_cls == POS;
  assign timeout     = adc_data_valid &&
                       !pulse_start &&
                       state != DIVIDE &&
                       (period_cnt + 32'd1 == MAX_PERIOD);
  assign div_start   = pulse_start &&
                       (state == MEASURE ||
                        (state == DIVIDE && div_done));
  assign q_sat       = (|quotient[31:16]) ? 16'hFFFF
                                          : quotient[15:0];

  pulse_meter_div32 u_div (
    .clk      (sys_clk),
    .rst      (sys_rst),
    .start    (div_start),
    .dividend (F_NUM),
    .divisor  (period_cnt),
    .busy     (div_busy),
    .done     (div_done),
    .quotient (quotient)
  );

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state            <= IDLE;
      prev_cls         <= ZERO;
      period_cnt       <= '0;
      pos_cnt          <= '0;
      pos_width        <= '0;
      f_measured       <= '0;
      f_measured_valid <= 1'b0;
      overrun          <= 1'b0;
      no_signal        <= 1'b1;
    end else begin
      f_measured_valid <= 1'b0;
      if (adc_data_valid) begin
        prev_cls   <= cur_cls;
        period_cnt <= pulse_start ? 32'd1
                                  : period_cnt + 32'd1;
        if (pulse_start)
          pos_cnt <= 16'd1;
        else if (cur_cls == POS && pos_cnt != 16'hFFFF)
          pos_cnt <= pos_cnt + 16'd1;
        if (lobe_end)
          pos_width <= pos_cnt;
      end
      unique case (state)
        IDLE: begin
          if (pulse_start) begin
            state <= MEASURE;
          end else if (timeout) begin
            f_measured       <= '0;
            f_measured_valid <= 1'b1;
            no_signal        <= 1'b1;
          end
        end
        MEASURE: begin
          if (pulse_start) begin
            state <= DIVIDE;
          end else if (timeout) begin
            f_measured       <= '0;
            f_measured_valid <= 1'b1;
            no_signal        <= 1'b1;
            state            <= IDLE;
          end
        end
        DIVIDE: begin
          // a start coinciding with done is captured as a new period
          if (div_done) begin
            f_measured       <= q_sat;
            f_measured_valid <= 1'b1;
            no_signal        <= 1'b0;
            if (!pulse_start)
              state <= MEASURE;
          end else if (pulse_start && div_busy) begin
            overrun <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_input_pulse_meter.sv
// Self-checking bench for input_pulse_meter: table rows, directed
// corner sequences and random streams against a reference model.
module tb_input_pulse_meter;

  localparam int MAXP = 2500;
  localparam int FNUM = 1000000;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [9:0]  adc = '0;
  logic        adc_v = 1'b0;
  logic [15:0] f_meas;
  logic        f_v;
  logic [15:0] pw;
  logic        ovr;
  logic        nosig;

  input_pulse_meter #(
    .MAX_PERIOD (MAXP)
  ) dut (
    .sys_clk          (clk),
    .sys_rst          (rst),
    .adc_data         (adc),
    .adc_data_valid   (adc_v),
    .f_measured       (f_meas),
    .f_measured_valid (f_v),
    .pos_width        (pw),
    .overrun          (ovr),
    .no_signal        (nosig)
  );

  always #5 clk = ~clk;

  int n_chk  = 0;
  int n_fail = 0;
  bit chk_en = 1'b0;
  int strobes = 0;
  int last_f  = -1;

  task automatic check(input string nm,
                       input int act,
                       input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d",
               nm, act, exp);
    end
  endtask

  // Reference model: valid-sample indices and result due times.
  int cyc = 0;
  int vidx = 0;
  int mref = 0;
  int due = -1;
  int mq = 0;
  int mode = 0;
  int run = 0;
  int mpw = 0;
  int mf = 0;
  bit mvalid = 1'b0;
  bit movr = 1'b0;
  bit mnosig = 1'b1;
  int prev_eff = 0;
  int prev_raw = 0;

  function automatic int cls(input logic [9:0] d);
    int s;
    s = $signed(d);
    if (s > 128) return 1;
    if (s < -128) return 2;
    return 0;
  endfunction

  always @(posedge clk) begin
    int raw;
    int eff;
    int mode0;
    int per;
    bit st;
    cyc++;
    if (rst) begin
      mode = 0; vidx = 0; mref = 0; due = -1;
      run = 0; mpw = 0; mf = 0;
      mvalid = 0; movr = 0; mnosig = 1;
      prev_eff = 0; prev_raw = 0;
    end else begin
      mvalid = 0;
      mode0 = mode;
      if (mode == 2 && cyc == due) begin
        mvalid = 1; mf = mq; mnosig = 0; mode = 1;
      end
      if (adc_v) begin
        raw = cls(adc);
`ifdef INPUT_PULSE_METER_GLITCH_FILTER_EN
        eff = (raw == prev_raw) ? raw : prev_eff;
`else
        eff = raw;
`endif
        prev_raw = raw;
        vidx++;
        st = (eff == 1 && prev_eff != 1);
        if (prev_eff == 1 && eff != 1) mpw = run;
        if (st) run = 1;
        else if (eff == 1 && run < 65535) run++;
        if (st) begin
          per = vidx - 1 - mref;
          mref = vidx - 1;
          if (mode == 0) begin
            mode = 1;
          end else if (mode == 1) begin
            mode = 2;
            due = cyc + 33;
            mq = FNUM / per;
            if (mq > 65535) mq = 65535;
          end else begin
            movr = 1;
          end
        end else if (mode0 != 2 &&
                     vidx - mref == MAXP) begin
          mvalid = 1; mf = 0; mnosig = 1; mode = 0;
        end
        prev_eff = eff;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("valid", int'(f_v), int'(mvalid));
      if (mvalid) check("f_measured", int'(f_meas), mf);
      check("pos_width", int'(pw), mpw);
      check("overrun", int'(ovr), int'(movr));
      check("no_signal", int'(nosig), int'(mnosig));
      if (f_v) begin
        strobes++;
        last_f = f_meas;
      end
    end
  end

  task automatic smp(input logic [9:0] d, input logic v);
    @(negedge clk);
    adc   = d;
    adc_v = v;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1; adc = '0; adc_v = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  typedef struct {
    int         per;
    int         w;
    int         spk;
    bit         gap;
    int         nfr;
    logic [9:0] lv;
    logic [9:0] nv;
    int         ef;
    int         ew;
    bit         eo;
    bit         ens;
  } row_t;

  row_t tbl[9];

  task automatic frame(input row_t r);
    logic [9:0] d;
    for (int i = 0; i < r.per; i++) begin
      if (i < r.w) d = r.lv;
      else if (i < 2 * r.w) d = r.nv;
      else if (r.spk > 0 && i == r.spk) d = 10'h1FF;
      else d = 10'h000;
      smp(d, 1'b1);
      if (r.gap) smp(10'($urandom), 1'b0);
    end
  endtask

  logic [9:0] bset[7];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    bset = '{10'd128, 10'd129, 10'h380, 10'h37F,
             10'h1FF, 10'h200, 10'h000};
    tbl[0] = '{1000, 5, 0, 0, 3, 10'h1FF, 10'h200,
               1000, 5, 1'b0, 1'b0};
    tbl[1] = '{10, 2, 0, 0, 20, 10'h1FF, 10'h200,
               65535, 2, 1'b1, 1'b0};
    tbl[2] = '{8, 2, 0, 0, 24, 10'h1FF, 10'h200,
               65535, 2, 1'b1, 1'b0};
    tbl[3] = '{100, 3, 0, 1, 4, 10'h1FF, 10'h200,
               10000, 3, 1'b0, 1'b0};
`ifdef INPUT_PULSE_METER_GLITCH_FILTER_EN
    tbl[4] = '{500, 5, 250, 0, 3, 10'h1FF, 10'h200,
               2000, 5, 1'b0, 1'b0};
`else
    tbl[4] = '{500, 5, 250, 0, 3, 10'h1FF, 10'h200,
               4000, 1, 1'b0, 1'b0};
`endif
    tbl[5] = '{40, 4, 0, 0, 6, 10'h1FF, 10'h200,
               25000, 4, 1'b0, 1'b0};
    tbl[6] = '{250, 6, 0, 1, 3, 10'h1FF, 10'h200,
               4000, 6, 1'b0, 1'b0};
    tbl[7] = '{200, 4, 0, 0, 3, 10'd129, 10'h37F,
               5000, 4, 1'b0, 1'b0};
    tbl[8] = '{200, 4, 0, 0, 3, 10'd128, 10'h380,
               -1, 0, 1'b0, 1'b1};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    chk_en = 1'b1;

    do_reset();
    @(negedge clk);
    check("rst_f", int'(f_meas), 0);
    check("rst_valid", int'(f_v), 0);
    check("rst_pw", int'(pw), 0);
    check("rst_ovr", int'(ovr), 0);
    check("rst_nosig", int'(nosig), 1);

    foreach (tbl[k]) begin
      do_reset();
      strobes = 0;
      last_f  = -1;
      for (int f = 0; f < tbl[k].nfr; f++) frame(tbl[k]);
      repeat (40) smp(10'h000, 1'b1);
      @(negedge clk);
      check($sformatf("row%0d_strobe", k),
            int'(strobes > 0), int'(tbl[k].ef >= 0));
      if (tbl[k].ef >= 0)
        check($sformatf("row%0d_f", k), last_f, tbl[k].ef);
      check($sformatf("row%0d_w", k), int'(pw), tbl[k].ew);
      check($sformatf("row%0d_ovr", k),
            int'(ovr), int'(tbl[k].eo));
      check($sformatf("row%0d_nosig", k),
            int'(nosig), int'(tbl[k].ens));
    end

    // loss of signal after lock: exactly one zero strobe
    do_reset();
    repeat (2) frame(tbl[0]);
    repeat (100) smp(10'h000, 1'b1);
    check("lock_nosig", int'(nosig), 0);
    strobes = 0;
    repeat (2 * MAXP) smp(10'h000, 1'b1);
    @(negedge clk);
    check("los_strobes", strobes, 1);
    check("los_f", last_f, 0);
    check("los_nosig", int'(nosig), 1);

    // idle timeout straight out of reset strobes once
    do_reset();
    strobes = 0;
    last_f  = -1;
    repeat (2 * MAXP) smp(10'h000, 1'b1);
    @(negedge clk);
    check("idle_strobes", strobes, 1);
    check("idle_f", last_f, 0);
    check("idle_nosig", int'(nosig), 1);

    // reset during a division suppresses the strobe
    do_reset();
    frame(tbl[7]);
    strobes = 0;
    for (int i = 0; i < 12; i++)
      smp(i < 3 ? 10'h1FF : i < 6 ? 10'h200 : 10'h000,
          1'b1);
    do_reset();
    repeat (60) smp(10'h000, 1'b1);
    @(negedge clk);
    check("abort_strobes", strobes, 0);
    check("abort_f", int'(f_meas), 0);
    check("abort_nosig", int'(nosig), 1);

    // random streams with boundary noise and invalid gaps
    do_reset();
    for (int k = 0; k < 40; k++) begin
      int per;
      int w;
      logic [9:0] d;
      per = (k % 5 == 4) ? $urandom_range(8, 20)
                         : $urandom_range(40, 300);
      w = $urandom_range(2, 6);
      if (k == 20) do_reset();
      for (int i = 0; i < per; i++) begin
        if (i < w) d = 10'h1FF;
        else if (i < 2 * w) d = 10'h200;
        else d = 10'h000;
        if ($urandom_range(0, 15) == 0)
          d = bset[$urandom_range(0, 6)];
        if ($urandom_range(0, 3) == 0)
          smp(10'($urandom), 1'b0);
        smp(d, 1'b1);
      end
    end
    repeat (40) smp(10'h000, 1'b1);
    @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
